// File: rtl/instruction_line_extractor.sv
// Buffers up to two L1I cachelines and streams one 32-bit instruction per cycle
// with its effective address, from the fetch offset to the end of each line.
module instruction_line_extractor #(
  parameter int offsetSize          = 5,
  parameter int indexSize           = 8,
  parameter int tagSize             = 64 - (offsetSize + indexSize),
  parameter int cachelineSizeInBits = (2 ** offsetSize) * 8,
  parameter int instrsPerLine       = 2 ** (offsetSize - 2)
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic [tagSize-1:0]             tag_i,
  input  logic [indexSize-1:0]           index_i,
  input  logic [offsetSize-1:0]          offset_i,
  input  logic [cachelineSizeInBits-1:0] cacheline_i,
  input  logic                           stall_i,
  input  logic                           flush_i,
  output logic                           ready_o,
  output logic [31:0]                    instruction_o,
  output logic [63:0]                    instrAddr_o,
  output logic                           lastInLine_o,
  output logic                           enable_o,
  output logic                           overflow_o
);

  localparam int WordBits = offsetSize - 2;
  localparam logic [WordBits-1:0] LastWord = WordBits'(instrsPerLine - 1);

  logic [tagSize-1:0]             tag_q   [2];
  logic [indexSize-1:0]           index_q [2];
  logic [WordBits-1:0]            start_q [2];
  logic [cachelineSizeInBits-1:0] line_q  [2];

  logic [1:0]          count_q;
  logic                wr_q;
  logic                rd_q;
  logic [WordBits-1:0] ptr_q;
  logic [WordBits-1:0] ptr_d;
  logic [WordBits-1:0] start_in;
  logic                push;
  logic                pop;
  logic                unused_offset_bits;

  // The two low offset bits select a byte within a word and play no part here.
  assign unused_offset_bits = ^offset_i[1:0];
  assign start_in = offset_i[offsetSize-1:2];
  assign ready_o  = (count_q != 2'd2);
  assign push     = enable_i && (count_q != 2'd2);
  assign pop      = !stall_i && (count_q != 2'd0) && (ptr_q == LastWord);

  // The word pointer always tracks the current head entry, so it is reloaded
  // whenever a different entry becomes head (pop, or push into an empty FIFO).
  always_comb begin
    ptr_d = ptr_q;
    if (pop) begin
      if (count_q == 2'd2)
        ptr_d = start_q[~rd_q];
      else if (push)
        ptr_d = start_in;
      else
        ptr_d = '0;
    end else if (!stall_i && (count_q != 2'd0)) begin
      ptr_d = ptr_q + WordBits'(1);
    end else if (push && (count_q == 2'd0)) begin
      ptr_d = start_in;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      tag_q[wr_q]   <= tag_i;
      index_q[wr_q] <= index_i;
      start_q[wr_q] <= start_in;
      line_q[wr_q]  <= cacheline_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      count_q       <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      ptr_q         <= '0;
      instruction_o <= '0;
      instrAddr_o   <= '0;
      lastInLine_o  <= 1'b0;
      enable_o      <= 1'b0;
      overflow_o    <= 1'b0;
    end else if (flush_i) begin
      count_q      <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      ptr_q        <= '0;
      enable_o     <= 1'b0;
      lastInLine_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      overflow_o <= enable_i && (count_q == 2'd2);
      count_q    <= count_q + {1'b0, push} - {1'b0, pop};
      ptr_q      <= ptr_d;
      if (push)
        wr_q <= ~wr_q;
      if (pop)
        rd_q <= ~rd_q;
      if (!stall_i) begin
        if (count_q != 2'd0) begin
          instruction_o <= line_q[rd_q][int'(ptr_q)*32 +: 32];
          instrAddr_o   <= {tag_q[rd_q], index_q[rd_q], ptr_q, 2'b00};
          lastInLine_o  <= (ptr_q == LastWord);
          enable_o      <= 1'b1;
        end else begin
          enable_o <= 1'b0;
        end
      end
    end
  end

endmodule
